opti_seq_ctrl: RTL
==================

OPTI_SEQ_CTRL -- requirements
Module: opti_seq_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, default 24, sample width; LEN_W, default 12, frame-length and address width; SETTLE, default 8, outputs per frame before stable_out; TIMEOUT, default 256, maximum idle cycles between outputs.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: frame start request, honoured only in IDLE.
REQ-006 Port abort, input, 1 bit: abandons the current frame from any state.
REQ-007 Port cont_mode, input, 1 bit: when 1, the next frame starts automatically after DONE.
REQ-008 Port frame_len, input, LEN_W bits: frame length in samples; sampled into len_q on an accepted start.
REQ-009 Port data_in_valid, input, 1 bit: an input sample enters the filter pipeline this cycle.
REQ-010 Ports sos_out_valid (input, 1 bit) and sos_out_data (input, signed DATA_W bits): output of the last filter section.
REQ-011 Port out_ready, input, 1 bit: downstream accepts data_out this cycle.
REQ-012 Port pipeline_en, output, 1 bit: filter pipeline enable.
REQ-013 Port in_ready, output, 1 bit: block still accepting input samples.
REQ-014 Ports addr (output, LEN_W bits) and data_out (output, signed DATA_W bits): sample index and sample value.
REQ-015 Port data_out_valid, output, 1 bit: data_out/addr valid.
REQ-016 Port stable_out, output, 1 bit: SETTLE outputs of the current frame have been seen.
REQ-017 Port filter_done, output, 1 bit: one-cycle pulse on frame completion.
REQ-018 Port busy, output, 1 bit: state is not IDLE.
REQ-019 Ports timeout_err and overflow_err, outputs, 1 bit each: sticky error flags.

Function
REQ-020 States SHALL be IDLE, RUN, DRAIN and DONE.
REQ-021 IDLE SHALL go to RUN on start=1 with frame_len!=0; start with frame_len==0 SHALL be ignored.
REQ-022 RUN SHALL go to DRAIN when in_cnt reaches len_q.
REQ-023 DRAIN SHALL go to DONE when out_cnt reaches len_q.
REQ-024 DONE SHALL last 1 cycle, then go to RUN if cont_mode=1, else to IDLE.
REQ-025 On DONE->RUN, len_q SHALL be re-sampled from frame_len; frame_len==0 at that point SHALL send the block to IDLE instead.
REQ-026 Entering RUN SHALL clear in_cnt, out_cnt, the idle counter and stable_out, and SHALL clear both error flags.
REQ-027 pipeline_en SHALL be 1 exactly while state is RUN or DRAIN (registered, same cycle as state).
REQ-028 in_ready SHALL be 1 exactly while state is RUN.
REQ-029 in_cnt SHALL increment on data_in_valid && state==RUN; data_in_valid outside RUN SHALL be ignored.
REQ-030 out_cnt SHALL increment on sos_out_valid in RUN or DRAIN while out_cnt<len_q.
REQ-031 sos_out_valid in IDLE or DONE, or with out_cnt>=len_q, SHALL be ignored.
REQ-032 Output register: a counted sample SHALL load data_out<=sos_out_data, addr<=out_cnt (0-based) and data_out_valid<=1 one cycle later.
REQ-033 The output register SHALL load only when it is empty or out_ready=1 in that cycle.
REQ-034 data_out_valid SHALL hold with data_out and addr stable until out_ready=1, then clear unless reloaded in the same cycle.
REQ-035 A counted sample arriving while data_out_valid=1 and out_ready=0 SHALL be dropped, still counted, and SHALL set overflow_err.
REQ-036 stable_out SHALL set in the cycle after the SETTLE-th counted output of the frame and stay set until the next RUN entry, abort or rst.
REQ-037 If SETTLE > len_q, stable_out SHALL stay 0 for that frame.
REQ-038 The idle counter SHALL count RUN/DRAIN cycles since the last sos_out_valid.
REQ-039 When the idle counter reaches TIMEOUT, the block SHALL set timeout_err, go to IDLE and pulse no filter_done.
REQ-040 filter_done SHALL be 1 for exactly the DONE cycle.
REQ-041 Abort SHALL force IDLE next cycle from any state with no filter_done; data_out_valid SHALL clear, error flags SHALL be kept and stable_out SHALL clear.
REQ-042 Abort SHALL take priority over start, timeout and completion in the same cycle.
REQ-043 Counters SHALL be LEN_W bits wide with no wrap, since they saturate at len_q.
REQ-044 len_q = 2^LEN_W-1 SHALL be supported.

Reset
REQ-045 On rst=1 at a clock edge, state SHALL be IDLE, all counters and len_q SHALL be 0, and every output SHALL be 0, including data_out and addr.
REQ-046 Reset SHALL override abort, start and all other inputs.
REQ-047 Reset asserted mid-frame SHALL take effect on the next edge with no filter_done pulse.

Verification
REQ-048 frame_len=16, start, 16 inputs, 16 outputs, out_ready=1 -> addr 0..15 in order, filter_done one pulse, then IDLE.
REQ-049 cont_mode=1, frame_len=4, two frames -> DONE goes straight to RUN, filter_done twice, busy stays 1.
REQ-050 out_ready=0 for 3 cycles with consecutive outputs -> data_out held, overflow_err=1, out_cnt still reaches len_q.
REQ-051 RUN with no sos_out_valid for 256 cycles -> timeout_err=1, IDLE, pipeline_en=0, no filter_done.
REQ-052 abort and start asserted in the same cycle mid-DRAIN -> IDLE next cycle, start ignored; frame_len=0 start -> stays IDLE.
REQ-053 SETTLE=8, frame_len=20 -> stable_out rises in the cycle after the 8th output; with frame_len=5, stable_out never rises.

Source files
------------

// File: rtl/opti_seq_ctrl.sv
// Frame sequencer for a cascaded filter pipeline: it gates the pipeline,
// counts samples in and out, registers outputs and flags timeout/overflow.
module opti_seq_ctrl #(
   parameter int DATA_W  = 24,
   parameter int LEN_W   = 12,
   parameter int SETTLE  = 8,
   parameter int TIMEOUT = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     cont_mode,
   input  logic [LEN_W-1:0]         frame_len,
   input  logic                     data_in_valid,
   input  logic                     sos_out_valid,
   input  logic signed [DATA_W-1:0] sos_out_data,
   input  logic                     out_ready,
   output logic                     pipeline_en,
   output logic                     in_ready,
   output logic [LEN_W-1:0]         addr,
   output logic signed [DATA_W-1:0] data_out,
   output logic                     data_out_valid,
   output logic                     stable_out,
   output logic                     filter_done,
   output logic                     busy,
   output logic                     timeout_err,
   output logic                     overflow_err
);

   localparam int IW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                   state_q, state_d;
   logic [LEN_W-1:0]         len_q, len_d;
   logic [LEN_W-1:0]         in_cnt_q, in_cnt_d;
   logic [LEN_W-1:0]         out_cnt_q, out_cnt_d;
   logic [LEN_W-1:0]         addr_q, addr_d;
   logic [IW-1:0]            idle_q, idle_d;
   logic signed [DATA_W-1:0] dout_q, dout_d;
   logic                     dov_q, dov_d;
   logic                     stb_q, stb_d;
   logic                     tmo_q, tmo_d;
   logic                     ovf_q, ovf_d;
   logic                     active, counted, load, enter_run;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      addr_d    = addr_q;
      idle_d    = idle_q;
      dout_d    = dout_q;
      dov_d     = dov_q;
      stb_d     = stb_q;
      tmo_d     = tmo_q;
      ovf_d     = ovf_q;
      enter_run = 1'b0;

      active  = (state_q == RUN) || (state_q == DRAIN);
      counted = active && sos_out_valid && (out_cnt_q < len_q);
      load    = counted && (!dov_q || out_ready);

      if (dov_q && out_ready) dov_d = 1'b0;
      if (load) begin
         dov_d  = 1'b1;
         dout_d = sos_out_data;
         addr_d = out_cnt_q;
      end
      if (counted) begin
         out_cnt_d = out_cnt_q + 1'b1;
         if (!load) ovf_d = 1'b1;
         if (int'(out_cnt_q) + 1 == SETTLE) stb_d = 1'b1;
      end
      if (state_q == RUN && data_in_valid && in_cnt_q < len_q)
         in_cnt_d = in_cnt_q + 1'b1;
      if (active)
         idle_d = sos_out_valid ? '0 : idle_q + 1'b1;

      unique case (state_q)
         IDLE:    if (start && frame_len != '0) enter_run = 1'b1;
         RUN:     if (in_cnt_d == len_q) state_d = DRAIN;
         DRAIN:   if (out_cnt_d == len_q) state_d = DONE;
         DONE: begin
            if (cont_mode && frame_len != '0) enter_run = 1'b1;
            else state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (active && int'(idle_d) == TIMEOUT) begin
         tmo_d   = 1'b1;
         state_d = IDLE;
      end

      if (enter_run) begin
         state_d   = RUN;
         len_d     = frame_len;
         in_cnt_d  = '0;
         out_cnt_d = '0;
         idle_d    = '0;
         stb_d     = 1'b0;
         tmo_d     = 1'b0;
         ovf_d     = 1'b0;
      end

      // Abort wins over everything except reset; error flags survive it.
      if (abort) begin
         state_d   = IDLE;
         in_cnt_d  = '0;
         out_cnt_d = '0;
         idle_d    = '0;
         dov_d     = 1'b0;
         stb_d     = 1'b0;
         tmo_d     = tmo_q;
         ovf_d     = ovf_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         len_q     <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         addr_q    <= '0;
         idle_q    <= '0;
         dout_q    <= '0;
         dov_q     <= 1'b0;
         stb_q     <= 1'b0;
         tmo_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         addr_q    <= addr_d;
         idle_q    <= idle_d;
         dout_q    <= dout_d;
         dov_q     <= dov_d;
         stb_q     <= stb_d;
         tmo_q     <= tmo_d;
         ovf_q     <= ovf_d;
      end
   end

   assign pipeline_en    = (state_q == RUN) || (state_q == DRAIN);
   assign in_ready       = (state_q == RUN);
   assign busy           = (state_q != IDLE);
   assign filter_done    = (state_q == DONE);
   assign addr           = addr_q;
   assign data_out       = dout_q;
   assign data_out_valid = dov_q;
   assign stable_out     = stb_q;
   assign timeout_err    = tmo_q;
   assign overflow_err   = ovf_q;

endmodule
